frac_interpolator: RTL and testbench

// Fractional-step position generator for the rotating scandoubler: maps output pixels/lines onto

---
 rtl/frac_interpolator_if.sv | 33 +++
 rtl/frac_interpolator.sv | 154 +++++++++++++++
 tb/tb_frac_interpolator.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frac_interpolator_if.sv
// Bundle between the scan timing logic and one axis of the fractional position generator.
interface frac_interpolator_if #(
    parameter int bitwidth  = 10,
    parameter int fracwidth = 16
);
    logic [bitwidth-1:0]  num;
    logic [bitwidth-1:0]  den;
    logic [bitwidth-1:0]  limit;
    logic [bitwidth-1:0]  limit_out;
    logic                 newfraction;
    logic                 ready;
    logic                 step_reset;
    logic                 step_in;
    logic [fracwidth-1:0] step_offset;
    logic [bitwidth-1:0]  pan_offset;
    logic [bitwidth-1:0]  centre_offset;
    logic                 step_out;
    logic [bitwidth-1:0]  whole;
    logic [fracwidth-1:0] fraction;
    logic                 blank;

    modport master (
        output num, den, limit, newfraction, step_reset, step_in,
               step_offset, pan_offset, centre_offset,
        input  limit_out, ready, step_out, whole, fraction, blank
    );

    modport slave (
        input  num, den, limit, newfraction, step_reset, step_in,
               step_offset, pan_offset, centre_offset,
        output limit_out, ready, step_out, whole, fraction, blank
    );
endinterface

// File: rtl/frac_interpolator.sv
// Fractional-step source coordinate generator: a serial divider derives step = den/num and a
// fixed-point accumulator advances by that step per output pixel/line.
module frac_interpolator #(
    parameter int bitwidth  = 10,
    parameter int fracwidth = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    frac_interpolator_if.slave   bus
);
    localparam int QW = bitwidth + fracwidth;
    localparam int AW = QW + 1;
    localparam int CW = $clog2(QW + 1);

    localparam logic [0:0]          DIV_IDLE   = 1'b0;
    localparam logic [0:0]          DIV_RUN    = 1'b1;
    localparam logic [CW-1:0]       DIV_CYCLES = CW'(QW);
    localparam logic [CW-1:0]       DIV_LAST   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [QW-1:0]       STEP_ONE   = {{(QW-1){1'b0}}, 1'b1} << fracwidth;
    localparam logic [bitwidth-1:0] ONE_B      = {{(bitwidth-1){1'b0}}, 1'b1};

    logic [0:0]           div_state_r;
    logic [CW-1:0]        div_cnt_r;
    logic [bitwidth-1:0]  div_num_r;
    logic [bitwidth-1:0]  div_rem_r;
    logic [QW-1:0]        div_quo_r;
    logic [QW-1:0]        step_r;
    logic [AW-1:0]        acc_r;
    logic [bitwidth-1:0]  centre_cnt_r;
    logic [bitwidth-1:0]  run_cnt_r;
    logic [bitwidth-1:0]  limit_out_r;
    logic                 step_out_r;
    logic                 blank_r;

    logic [bitwidth:0]    div_trial_s;
    logic [bitwidth-1:0]  div_rem_next_s;
    logic                 div_qbit_s;
    logic [AW-1:0]        acc_sum_s;
    logic [AW-1:0]        acc_next_s;
    logic [bitwidth-1:0]  centre_next_s;
    logic [bitwidth-1:0]  run_next_s;
    logic [bitwidth-1:0]  limit_out_next_s;
    logic                 step_out_next_s;
    logic                 blank_next_s;

    // One restoring-division iteration: remainder shifts in the next dividend bit.
    always_comb begin
        div_trial_s    = {div_rem_r, div_quo_r[QW-1]};
        div_qbit_s     = 1'b0;
        div_rem_next_s = div_trial_s[bitwidth-1:0];
        if (div_trial_s >= {1'b0, div_num_r}) begin
            div_qbit_s     = 1'b1;
            div_rem_next_s = div_trial_s[bitwidth-1:0] - div_num_r;
        end else begin
            div_qbit_s     = 1'b0;
            div_rem_next_s = div_trial_s[bitwidth-1:0];
        end
    end

    // Divider sequencer; div_quo_r holds the dividend shifting out and the quotient shifting in.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_state_r <= DIV_IDLE;
            div_cnt_r   <= {CW{1'b0}};
            div_num_r   <= {bitwidth{1'b0}};
            div_rem_r   <= {bitwidth{1'b0}};
            div_quo_r   <= {QW{1'b0}};
            step_r      <= STEP_ONE;
        end else if (bus.newfraction) begin
            div_state_r <= DIV_RUN;
            div_cnt_r   <= DIV_CYCLES;
            div_num_r   <= bus.num;
            div_rem_r   <= {bitwidth{1'b0}};
            div_quo_r   <= {bus.den, {fracwidth{1'b0}}};
        end else begin
            case (div_state_r)
                DIV_RUN: begin
                    div_quo_r <= {div_quo_r[QW-2:0], div_qbit_s};
                    div_rem_r <= div_rem_next_s;
                    div_cnt_r <= div_cnt_r - DIV_LAST;
                    if (div_cnt_r == DIV_LAST) begin
                        div_state_r <= DIV_IDLE;
                        step_r      <= (div_num_r == {bitwidth{1'b0}}) ? {QW{1'b1}}
                                                                      : {div_quo_r[QW-2:0], div_qbit_s};
                    end
                end
                default: div_state_r <= DIV_IDLE;
            endcase
        end
    end

    // Next-state of the position accumulator, centring counter, blanking and extent counter.
    always_comb begin
        acc_sum_s        = acc_r + {1'b0, step_r};
        acc_next_s       = acc_r;
        centre_next_s    = centre_cnt_r;
        run_next_s       = run_cnt_r;
        limit_out_next_s = limit_out_r;
        step_out_next_s  = 1'b0;
        blank_next_s     = blank_r;
        if (bus.step_reset) begin
            acc_next_s       = {1'b0, bus.pan_offset, bus.step_offset};
            centre_next_s    = bus.centre_offset;
            limit_out_next_s = run_cnt_r;
            run_next_s       = {bitwidth{1'b0}};
            blank_next_s     = (bus.centre_offset != {bitwidth{1'b0}}) | (bus.pan_offset > bus.limit);
        end else if (bus.step_in) begin
            // Count the step if the position it leaves was visible.
            if (!blank_r && (run_cnt_r != {bitwidth{1'b1}})) begin
                run_next_s = run_cnt_r + ONE_B;
            end else begin
                run_next_s = run_cnt_r;
            end
            if (centre_cnt_r != {bitwidth{1'b0}}) begin
                centre_next_s = centre_cnt_r - ONE_B;
                blank_next_s  = 1'b1;
            end else if (acc_r[AW-1]) begin
                blank_next_s  = 1'b1;
            end else begin
                acc_next_s      = acc_sum_s;
                step_out_next_s = (acc_sum_s[AW-1:fracwidth] != acc_r[AW-1:fracwidth]);
                blank_next_s    = acc_sum_s[AW-1] | (acc_sum_s[AW-2:fracwidth] > bus.limit);
            end
        end else begin
            step_out_next_s = 1'b0;
        end
    end

    // Position state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r        <= {AW{1'b0}};
            centre_cnt_r <= {bitwidth{1'b0}};
            run_cnt_r    <= {bitwidth{1'b0}};
            limit_out_r  <= {bitwidth{1'b0}};
            step_out_r   <= 1'b0;
            blank_r      <= 1'b1;
        end else begin
            acc_r        <= acc_next_s;
            centre_cnt_r <= centre_next_s;
            run_cnt_r    <= run_next_s;
            limit_out_r  <= limit_out_next_s;
            step_out_r   <= step_out_next_s;
            blank_r      <= blank_next_s;
        end
    end

    assign bus.ready     = (div_state_r == DIV_IDLE);
    assign bus.whole     = acc_r[AW-2:fracwidth];
    assign bus.fraction  = acc_r[fracwidth-1:0];
    assign bus.step_out  = step_out_r;
    assign bus.blank     = blank_r;
    assign bus.limit_out = limit_out_r;
endmodule

// File: tb/tb_frac_interpolator.sv
// Directed-vector bench for frac_interpolator with hand-computed expectations.
module tb_frac_interpolator;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    frac_interpolator_if #(.bitwidth(10), .fracwidth(16)) bus ();

    frac_interpolator #(.bitwidth(10), .fracwidth(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start a division and count cycles with ready low, bounded.
    task automatic run_div(input logic [9:0] n, input logic [9:0] d, output int cycles);
        bus.num = n;
        bus.den = d;
        bus.newfraction = 1'b1;
        tick();
        bus.newfraction = 1'b0;
        cycles = 0;
        while (!bus.ready && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    task automatic pulse_step_reset(input logic [9:0] pan, input logic [15:0] off, input logic [9:0] ctr);
        bus.pan_offset    = pan;
        bus.step_offset   = off;
        bus.centre_offset = ctr;
        bus.step_reset    = 1'b1;
        tick();
        bus.step_reset    = 1'b0;
    endtask

    task automatic pulse_step_in;
        bus.step_in = 1'b1;
        tick();
        bus.step_in = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if ({bus.whole, bus.fraction, bus.ready, bus.step_out, bus.blank, bus.limit_out} !==
            {10'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 10'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got whole=%0d frac=%h ready=%b step_out=%b blank=%b limit_out=%0d, want 0 0000 1 0 1 0",
                     bus.whole, bus.fraction, bus.ready, bus.step_out, bus.blank, bus.limit_out);
        end
    endtask

    task automatic test_unity_step;
        int cyc;
        bus.limit = 10'd1023;
        run_div(10'd100, 10'd100, cyc);
        vectors++;
        if (cyc !== 26) begin
            miscompares++;
            $display("FAIL unity_div_cycles: got %0d want 26", cyc);
        end
        pulse_step_reset(10'd0, 16'h0000, 10'd0);
        for (int i = 1; i <= 4; i++) begin
            pulse_step_in();
            vectors++;
            if ({bus.whole, bus.fraction, bus.step_out} !== {10'(i), 16'h0000, 1'b1}) begin
                miscompares++;
                $display("FAIL unity_step%0d: got whole=%0d frac=%h step_out=%b want %0d 0000 1",
                         i, bus.whole, bus.fraction, bus.step_out, i);
            end
        end
    endtask

    task automatic test_half_step;
        int cyc;
        logic [9:0]  ew [4];
        logic [15:0] ef [4];
        logic        es [4];
        ew = '{10'd0, 10'd1, 10'd1, 10'd2};
        ef = '{16'h8000, 16'h0000, 16'h8000, 16'h0000};
        es = '{1'b0, 1'b1, 1'b0, 1'b1};
        run_div(10'd200, 10'd100, cyc);
        vectors++;
        if (cyc !== 26) begin
            miscompares++;
            $display("FAIL half_div_cycles: got %0d want 26", cyc);
        end
        pulse_step_reset(10'd0, 16'h0000, 10'd0);
        for (int i = 0; i < 4; i++) begin
            pulse_step_in();
            vectors++;
            if ({bus.whole, bus.fraction, bus.step_out} !== {ew[i], ef[i], es[i]}) begin
                miscompares++;
                $display("FAIL half_step%0d: got whole=%0d frac=%h step_out=%b want %0d %h %b",
                         i, bus.whole, bus.fraction, bus.step_out, ew[i], ef[i], es[i]);
            end
        end
    endtask

    // Old step (0.5) stays in use mid-division; a second newfraction restarts the divide.
    task automatic test_back_to_back;
        int cyc;
        bus.num = 10'd100;
        bus.den = 10'd100;
        bus.newfraction = 1'b1;
        tick();
        bus.newfraction = 1'b0;
        vectors++;
        if (bus.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_ready_low: got %b want 0", bus.ready);
        end
        pulse_step_reset(10'd0, 16'h0000, 10'd0);
        pulse_step_in();
        vectors++;
        if ({bus.whole, bus.fraction} !== {10'd0, 16'h8000}) begin
            miscompares++;
            $display("FAIL b2b_old_step1: got whole=%0d frac=%h want 0 8000", bus.whole, bus.fraction);
        end
        pulse_step_in();
        vectors++;
        if ({bus.whole, bus.fraction} !== {10'd1, 16'h0000}) begin
            miscompares++;
            $display("FAIL b2b_old_step2: got whole=%0d frac=%h want 1 0000", bus.whole, bus.fraction);
        end
        run_div(10'd50, 10'd100, cyc);
        vectors++;
        if (cyc !== 26) begin
            miscompares++;
            $display("FAIL b2b_restart_cycles: got %0d want 26", cyc);
        end
        pulse_step_reset(10'd0, 16'h0000, 10'd0);
        pulse_step_in();
        vectors++;
        if ({bus.whole, bus.fraction, bus.step_out} !== {10'd2, 16'h0000, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_new_step: got whole=%0d frac=%h step_out=%b want 2 0000 1",
                     bus.whole, bus.fraction, bus.step_out);
        end
    endtask

    task automatic test_centre;
        int cyc;
        bus.limit = 10'd100;
        run_div(10'd100, 10'd100, cyc);
        pulse_step_reset(10'd5, 16'h0000, 10'd3);
        vectors++;
        if ({bus.whole, bus.blank} !== {10'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL centre_load: got whole=%0d blank=%b want 5 1", bus.whole, bus.blank);
        end
        for (int i = 1; i <= 3; i++) begin
            pulse_step_in();
            vectors++;
            if ({bus.whole, bus.blank, bus.step_out} !== {10'd5, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL centre_hold%0d: got whole=%0d blank=%b step_out=%b want 5 1 0",
                         i, bus.whole, bus.blank, bus.step_out);
            end
        end
        pulse_step_in();
        vectors++;
        if ({bus.whole, bus.blank, bus.step_out} !== {10'd6, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL centre_release: got whole=%0d blank=%b step_out=%b want 6 0 1",
                     bus.whole, bus.blank, bus.step_out);
        end
    endtask

    task automatic test_limit;
        logic exp_blank;
        bus.limit = 10'd5;
        pulse_step_reset(10'd0, 16'h0000, 10'd0);
        vectors++;
        if (bus.blank !== 1'b0) begin
            miscompares++;
            $display("FAIL limit_start_blank: got %b want 0", bus.blank);
        end
        for (int i = 1; i <= 7; i++) begin
            pulse_step_in();
            exp_blank = (i > 5);
            vectors++;
            if ({bus.whole, bus.blank} !== {10'(i), exp_blank}) begin
                miscompares++;
                $display("FAIL limit_step%0d: got whole=%0d blank=%b want %0d %b",
                         i, bus.whole, bus.blank, i, exp_blank);
            end
        end
        pulse_step_reset(10'd0, 16'h0000, 10'd0);
        vectors++;
        if (bus.limit_out !== 10'd6) begin
            miscompares++;
            $display("FAIL limit_out: got %0d want 6", bus.limit_out);
        end
    endtask

    task automatic test_same_cycle;
        bus.pan_offset    = 10'd7;
        bus.step_offset   = 16'h1234;
        bus.centre_offset = 10'd0;
        bus.step_reset    = 1'b1;
        bus.step_in       = 1'b1;
        tick();
        bus.step_reset    = 1'b0;
        bus.step_in       = 1'b0;
        vectors++;
        if ({bus.whole, bus.fraction, bus.step_out} !== {10'd7, 16'h1234, 1'b0}) begin
            miscompares++;
            $display("FAIL same_cycle: got whole=%0d frac=%h step_out=%b want 7 1234 0",
                     bus.whole, bus.fraction, bus.step_out);
        end
    endtask

    // num=0 saturates the step; the accumulator then overflows and holds.
    task automatic test_saturate;
        int cyc;
        bus.limit = 10'd1023;
        run_div(10'd0, 10'd50, cyc);
        vectors++;
        if (cyc !== 26) begin
            miscompares++;
            $display("FAIL sat_div_cycles: got %0d want 26", cyc);
        end
        pulse_step_reset(10'd0, 16'h0000, 10'd0);
        pulse_step_in();
        vectors++;
        if ({bus.whole, bus.fraction, bus.blank, bus.step_out} !== {10'h3FF, 16'hFFFF, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL sat_step1: got whole=%h frac=%h blank=%b step_out=%b want 3ff ffff 0 1",
                     bus.whole, bus.fraction, bus.blank, bus.step_out);
        end
        pulse_step_in();
        vectors++;
        if ({bus.whole, bus.fraction, bus.blank, bus.step_out} !== {10'h3FF, 16'hFFFE, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL sat_overflow: got whole=%h frac=%h blank=%b step_out=%b want 3ff fffe 1 1",
                     bus.whole, bus.fraction, bus.blank, bus.step_out);
        end
        pulse_step_in();
        vectors++;
        if ({bus.whole, bus.fraction, bus.blank, bus.step_out} !== {10'h3FF, 16'hFFFE, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sat_hold: got whole=%h frac=%h blank=%b step_out=%b want 3ff fffe 1 0",
                     bus.whole, bus.fraction, bus.blank, bus.step_out);
        end
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        reset             = 1'b1;
        bus.num           = 10'd0;
        bus.den           = 10'd0;
        bus.limit         = 10'd1023;
        bus.newfraction   = 1'b0;
        bus.step_reset    = 1'b0;
        bus.step_in       = 1'b0;
        bus.step_offset   = 16'h0000;
        bus.pan_offset    = 10'd0;
        bus.centre_offset = 10'd0;
        test_reset();
        test_unity_step();
        test_half_step();
        test_back_to_back();
        test_centre();
        test_limit();
        test_same_cycle();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
